// File: rtl/mini_src_pkg.sv
// rtl/mini_src_pkg.sv - Mini-SRC opcode, ALU opcode, instruction class and sequencer state encodings
package mini_src_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHL  = 5'b01000;
   localparam logic [4:0] OP_ROR  = 5'b01001;
   localparam logic [4:0] OP_ROL  = 5'b01010;
   localparam logic [4:0] OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_ANDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01101;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_NEG  = 5'b10000;
   localparam logic [4:0] OP_NOT  = 5'b10001;
   localparam logic [4:0] OP_MFHI = 5'b10111;
   localparam logic [4:0] OP_MFLO = 5'b11000;
   localparam logic [4:0] OP_NOP  = 5'b11001;
   localparam logic [4:0] OP_HALT = 5'b11010;

   // Shared with alu_32; do not renumber.
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_SHR = 4'd4;
   localparam logic [3:0] ALU_SHL = 4'd5;
   localparam logic [3:0] ALU_ROR = 4'd6;
   localparam logic [3:0] ALU_ROL = 4'd7;
   localparam logic [3:0] ALU_MUL = 4'd8;
   localparam logic [3:0] ALU_DIV = 4'd9;
   localparam logic [3:0] ALU_NEG = 4'd10;
   localparam logic [3:0] ALU_NOT = 4'd11;

   typedef enum logic [3:0] {
      ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
   } state_t;

   typedef enum logic [3:0] {
      CLS_RTYPE, CLS_IMM, CLS_UNARY, CLS_MULDIV, CLS_LD, CLS_ST,
      CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT, CLS_ILLEGAL
   } instr_class_t;

endpackage

// File: rtl/mini_src_ir_decode.sv
// rtl/mini_src_ir_decode.sv - opcode to instruction class and ALU opcode
// mul/div are decoded only when MINI_SRC_CTRL_MULDIV_EN is defined; otherwise they are illegal.
import mini_src_pkg::*;

module mini_src_ir_decode (
   input  logic [4:0]   opcode,
   output instr_class_t instr_class,
   output logic [3:0]   alu_op
);

   always_comb begin
      instr_class = CLS_ILLEGAL;
      alu_op      = ALU_ADD;
      case (opcode)
         OP_ADD:  begin instr_class = CLS_RTYPE; alu_op = ALU_ADD; end
         OP_SUB:  begin instr_class = CLS_RTYPE; alu_op = ALU_SUB; end
         OP_AND:  begin instr_class = CLS_RTYPE; alu_op = ALU_AND; end
         OP_OR:   begin instr_class = CLS_RTYPE; alu_op = ALU_OR;  end
         OP_SHR:  begin instr_class = CLS_RTYPE; alu_op = ALU_SHR; end
         OP_SHL:  begin instr_class = CLS_RTYPE; alu_op = ALU_SHL; end
         OP_ROR:  begin instr_class = CLS_RTYPE; alu_op = ALU_ROR; end
         OP_ROL:  begin instr_class = CLS_RTYPE; alu_op = ALU_ROL; end
         OP_ADDI: begin instr_class = CLS_IMM;   alu_op = ALU_ADD; end
         OP_ANDI: begin instr_class = CLS_IMM;   alu_op = ALU_AND; end
         OP_ORI:  begin instr_class = CLS_IMM;   alu_op = ALU_OR;  end
         OP_LDI:  begin instr_class = CLS_IMM;   alu_op = ALU_ADD; end
         OP_NEG:  begin instr_class = CLS_UNARY; alu_op = ALU_NEG; end
         OP_NOT:  begin instr_class = CLS_UNARY; alu_op = ALU_NOT; end
`ifdef MINI_SRC_CTRL_MULDIV_EN
         OP_MUL:  begin instr_class = CLS_MULDIV; alu_op = ALU_MUL; end
         OP_DIV:  begin instr_class = CLS_MULDIV; alu_op = ALU_DIV; end
`endif
         // Effective address for ld/st is rb + C through the adder.
         OP_LD:   begin instr_class = CLS_LD;    alu_op = ALU_ADD; end
         OP_ST:   begin instr_class = CLS_ST;    alu_op = ALU_ADD; end
         OP_MFHI: instr_class = CLS_MFHI;
         OP_MFLO: instr_class = CLS_MFLO;
         OP_NOP:  instr_class = CLS_NOP;
         OP_HALT: instr_class = CLS_HALT;
         default: instr_class = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mini_src_control_unit.sv
// rtl/mini_src_control_unit.sv - Mini-SRC multi-cycle control sequencer (fetch T0-T2, execute T3-T7)
// Define MINI_SRC_CTRL_MULDIV_EN to build the mul/div execute sequences.
import mini_src_pkg::*;

module mini_src_control_unit (
   input  logic        clk,
   input  logic        in_clr,
   input  logic [31:0] in_ir,
   input  logic        in_mem_ready,
   output logic        out_reg_clear,
   output logic [3:0]  out_regfile_location,
   output logic [3:0]  out_alu_opcode,
   output logic        out_mdr_select,
   output logic        out_inc_pc,
   output logic        out_regfile_read,
   output logic        out_hi_read,
   output logic        out_lo_read,
   output logic        out_z_hi_read,
   output logic        out_z_lo_read,
   output logic        out_pc_read,
   output logic        out_mdr_read,
   output logic        out_c_read,
   output logic        out_regfile_write,
   output logic        out_hi_write,
   output logic        out_lo_write,
   output logic        out_z_write,
   output logic        out_pc_write,
   output logic        out_mdr_write,
   output logic        out_ir_write,
   output logic        out_y_write,
   output logic        out_mar_write,
   output logic        out_mem_read,
   output logic        out_mem_write,
   output logic        out_halted,
   output logic        out_illegal
);

   state_t       state, state_next;
   instr_class_t cls;
   logic [3:0]   dec_alu_op;
   logic [3:0]   ra, rb, rc;
   logic         unused_ir_low;

   assign ra            = in_ir[26:23];
   assign rb            = in_ir[22:19];
   assign rc            = in_ir[18:15];
   assign unused_ir_low = ^in_ir[14:0];

   mini_src_ir_decode u_decode (
      .opcode      (in_ir[31:27]),
      .instr_class (cls),
      .alu_op      (dec_alu_op)
   );

   always_ff @(posedge clk) begin
      if (in_clr) state <= ST_RESET;
      else        state <= state_next;
   end

   always_comb begin
      state_next           = state;
      out_reg_clear        = 1'b0;
      out_regfile_location = 4'd0;
      out_alu_opcode       = 4'd0;
      out_mdr_select       = 1'b0;
      out_inc_pc           = 1'b0;
      out_regfile_read     = 1'b0;
      out_hi_read          = 1'b0;
      out_lo_read          = 1'b0;
      out_z_hi_read        = 1'b0;
      out_z_lo_read        = 1'b0;
      out_pc_read          = 1'b0;
      out_mdr_read         = 1'b0;
      out_c_read           = 1'b0;
      out_regfile_write    = 1'b0;
      out_hi_write         = 1'b0;
      out_lo_write         = 1'b0;
      out_z_write          = 1'b0;
      out_pc_write         = 1'b0;
      out_mdr_write        = 1'b0;
      out_ir_write         = 1'b0;
      out_y_write          = 1'b0;
      out_mar_write        = 1'b0;
      out_mem_read         = 1'b0;
      out_mem_write        = 1'b0;
      out_halted           = 1'b0;
      out_illegal          = 1'b0;
      case (state)
         ST_RESET: begin
            out_reg_clear = 1'b1;
            state_next    = ST_T0;
         end
         // PC increments through its own adder while the old PC goes to MAR.
         ST_T0: begin
            out_pc_read = 1'b1; out_mar_write = 1'b1;
            out_inc_pc  = 1'b1; out_pc_write  = 1'b1;
            state_next  = ST_T1;
         end
         ST_T1: begin
            out_mem_read = 1'b1; out_mdr_select = 1'b1;
            if (in_mem_ready) begin
               out_mdr_write = 1'b1;
               state_next    = ST_T2;
            end
         end
         ST_T2: begin
            out_mdr_read = 1'b1; out_ir_write = 1'b1;
            state_next   = ST_T3;
         end
         ST_T3: begin
            state_next = ST_T4;
            case (cls)
               CLS_RTYPE, CLS_IMM, CLS_LD, CLS_ST: begin
                  out_regfile_read = 1'b1; out_regfile_location = rb; out_y_write = 1'b1;
               end
               CLS_UNARY: begin
                  out_regfile_read = 1'b1; out_regfile_location = rb;
                  out_alu_opcode   = dec_alu_op; out_z_write = 1'b1;
               end
               CLS_MULDIV: begin
                  out_regfile_read = 1'b1; out_regfile_location = ra; out_y_write = 1'b1;
               end
               CLS_MFHI: begin
                  out_hi_read = 1'b1; out_regfile_write = 1'b1; out_regfile_location = ra;
                  state_next  = ST_T0;
               end
               CLS_MFLO: begin
                  out_lo_read = 1'b1; out_regfile_write = 1'b1; out_regfile_location = ra;
                  state_next  = ST_T0;
               end
               CLS_HALT:    state_next = ST_HALT;
               CLS_ILLEGAL: begin
                  out_illegal = 1'b1;
                  state_next  = ST_T0;
               end
               default:     state_next = ST_T0;
            endcase
         end
         ST_T4: begin
            state_next = ST_T5;
            case (cls)
               CLS_RTYPE: begin
                  out_regfile_read = 1'b1; out_regfile_location = rc;
                  out_alu_opcode   = dec_alu_op; out_z_write = 1'b1;
               end
               CLS_IMM, CLS_LD, CLS_ST: begin
                  out_c_read = 1'b1; out_alu_opcode = dec_alu_op; out_z_write = 1'b1;
               end
               CLS_UNARY: begin
                  out_z_lo_read = 1'b1; out_regfile_write = 1'b1; out_regfile_location = ra;
                  state_next    = ST_T0;
               end
               CLS_MULDIV: begin
                  out_regfile_read = 1'b1; out_regfile_location = rb;
                  out_alu_opcode   = dec_alu_op; out_z_write = 1'b1;
               end
               default: state_next = ST_T0;
            endcase
         end
         ST_T5: begin
            state_next = ST_T0;
            case (cls)
               CLS_RTYPE, CLS_IMM: begin
                  out_z_lo_read = 1'b1; out_regfile_write = 1'b1; out_regfile_location = ra;
               end
               CLS_LD, CLS_ST: begin
                  out_z_lo_read = 1'b1; out_mar_write = 1'b1;
                  state_next    = ST_T6;
               end
               CLS_MULDIV: begin
                  out_z_lo_read = 1'b1; out_lo_write = 1'b1;
                  state_next    = ST_T6;
               end
               default: ;
            endcase
         end
         ST_T6: begin
            state_next = ST_T0;
            case (cls)
               CLS_LD: begin
                  out_mem_read = 1'b1; out_mdr_select = 1'b1;
                  if (in_mem_ready) begin
                     out_mdr_write = 1'b1;
                     state_next    = ST_T7;
                  end else begin
                     state_next    = ST_T6;
                  end
               end
               CLS_ST: begin
                  out_regfile_read = 1'b1; out_regfile_location = ra; out_mdr_write = 1'b1;
                  state_next       = ST_T7;
               end
               CLS_MULDIV: begin
                  out_z_hi_read = 1'b1; out_hi_write = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T7: begin
            state_next = ST_T0;
            case (cls)
               CLS_LD: begin
                  out_mdr_read = 1'b1; out_regfile_write = 1'b1; out_regfile_location = ra;
               end
               CLS_ST: begin
                  out_mem_write = 1'b1;
                  if (!in_mem_ready) state_next = ST_T7;
               end
               default: ;
            endcase
         end
         ST_HALT: out_halted = 1'b1;
         default: state_next = ST_RESET;
      endcase
   end

endmodule

// File: doc/mini_src_control_unit.md
# mini_src_control_unit

Multi-cycle control sequencer for the Mini-SRC processor. It consumes the instruction register value from the datapath and drives every datapath read/write strobe, the register-file location, the ALU opcode, the MDR source select, the PC-increment select and the memory read/write handshake. It is the initiator side of the datapath's control interface: the datapath executes whatever strobes this block asserts in a given cycle.

## Interface
- No parameters; all encodings come from the shared package.
- clk  in  1  system clock; all state changes on the rising edge
- in_clr  in  1  reset, synchronous, active-high
- in_ir  in  32  IR contents: opcode [31:27], ra [26:23], rb [22:19], rc [18:15], C [18:0]
- in_mem_ready  in  1  memory has completed the current read or write this cycle
- out_reg_clear  out  1  clears all datapath registers
- out_regfile_location  out  4  register-file index for the current read or write
- out_alu_opcode  out  4  ALU operation, valid in the cycle out_z_write is high
- out_mdr_select  out  1  MDR source: 1 = memory, 0 = bus
- out_inc_pc  out  1  PC input taken from the PC adder
- out_regfile_read, out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read, out_pc_read, out_mdr_read, out_c_read  out  1 each  bus drivers; at most one is high per cycle
- out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write, out_mdr_write, out_ir_write, out_y_write, out_mar_write  out  1 each  register load enables
- out_mem_read, out_mem_write  out  1 each  memory request; held until in_mem_ready
- out_halted  out  1  high while in HALT
- out_illegal  out  1  one-cycle pulse on an unsupported opcode

## Operation
- States: RESET, T0–T7, HALT. Outputs are a combinational decode of the state and in_ir; the state is registered.
- RESET: only out_reg_clear=1. Goes to T0 on the first cycle with in_clr=0.
- T0: pc_read, mar_write, inc_pc, pc_write. The PC increments through its own adder in parallel with the bus transfer.
- T1: mem_read, mdr_select=1. Stays in T1 until in_mem_ready. mdr_write is high only in the ready cycle.
- T2: mdr_read, ir_write. Then goes to T3.
- T3 onward, by instruction class (location shown in brackets):
  - add/sub/and/or/shr/shl/ror/rol: T3 regfile_read[rb], y_write. T4 regfile_read[rc], alu op, z_write. T5 z_lo_read, regfile_write[ra].
  - addi/andi/ori/ldi: T3 regfile_read[rb], y_write. T4 c_read, op (ldi uses ADD), z_write. T5 z_lo_read, regfile_write[ra].
  - neg/not: T3 regfile_read[rb], op, z_write. T4 z_lo_read, regfile_write[ra].
  - mul/div: T3 regfile_read[ra], y_write. T4 regfile_read[rb], op, z_write. T5 z_lo_read, lo_write. T6 z_hi_read, hi_write.
  - ld: T3–T4 as ldi. T5 z_lo_read, mar_write. T6 mem_read, mdr_select=1, wait for ready, mdr_write in the ready cycle. T7 mdr_read, regfile_write[ra].
  - st: T3–T5 as ld. T6 regfile_read[ra], mdr_select=0, mdr_write. T7 mem_write, wait for ready.
  - mfhi/mflo: T3 hi_read/lo_read, regfile_write[ra].
  - nop: returns to T0 from T3.
  - halt: goes to HALT.
  - Any other opcode (br, jr, jal, in, out, reserved): out_illegal=1 in T3, then treated as nop.
- The last step of each class returns to T0.
- HALT: out_halted=1, all other outputs 0. Exits only through in_clr.

## Timing
- in_clr sampled high puts the state in RESET on that edge, from any state, including mid memory wait. An outstanding mem_read/mem_write is dropped in the following cycle.
- Reset value of every output is 0, except out_reg_clear=1.
- With in_mem_ready tied high, cycles per instruction from T0: R-type/imm 6, neg/not 5, mul/div 7, ld/st 8, mfhi/mflo 4, nop 4.
- Each cycle in_mem_ready stays low adds exactly one cycle. Request signals stay stable during the wait.
- in_ir is only decoded in T3 and later. IR is stable then because ir_write fires only in T2.

## Configuration
- MINI_SRC_CTRL_MULDIV_EN defined: mul/div sequences (T3–T6) are built.
- Not defined: mul/div opcodes take the illegal path (out_illegal pulse, nop). HI/LO are then only written externally, and mfhi/mflo remain supported.

## Structure
- Shared package mini_src_pkg holds:
  - 5-bit opcode constants: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, shr=00111, shl=01000, ror=01001, rol=01010, addi=01011, andi=01100, ori=01101, mul=01110, div=01111, neg=10000, not=10001, mfhi=10111, mflo=11000, nop=11001, halt=11010.
  - 4-bit ALU opcode constants: ADD=0, SUB=1, AND=2, OR=3, SHR=4, SHL=5, ROR=6, ROL=7, MUL=8, DIV=9, NEG=10, NOT=11. These are shared with alu_32.
  - The state enumeration.
- One sub-module: mini_src_ir_decode. It is combinational and maps the opcode to instruction class and ALU opcode. The FSM stays in the top module.

## Test plan
- Reset: in_clr high for 2 cycles, then low → out_reg_clear=1 for one cycle; T0 next cycle with pc_read, mar_write, inc_pc, pc_write all 1.
- add r1,r2,r3 (in_ir=0x18918000), ready tied high:
  - T3: regfile_read, location 2, y_write.
  - T4: location 3, z_write, alu_opcode 0.
  - T5: z_lo_read, regfile_write, location 1.
  - T0 on the 7th cycle.
- ld r4,0x10(r2) (0x02100010), in_mem_ready low for 3 cycles in T6 → mem_read held 4 cycles; mdr_write only in the ready cycle; T7 regfile_write, location 4.
- mul r6,r7 (0x73380000):
  - With MULDIV_EN: lo_write in T5, hi_write in T6.
  - Without MULDIV_EN: out_illegal pulses in T3, then T0.
- halt (0xD0000000) → out_halted=1 steady for 20 cycles; mfhi r5 (0xBA800000) after reset completes in 4 cycles.
- in_clr asserted during the T7 memory wait of st → RESET on the next edge, out_mem_write=0 the following cycle.
